// File: rtl/adc_sar_redundant_reconstruction_pkg.sv
// Shared FSM encodings and width helpers for the redundant-weight SAR reconstruction block.
package adc_sar_redundant_reconstruction_pkg;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_CONV = 2'd1;
    localparam logic [1:0] R_DONE = 2'd2;

    // Accumulator width: worst case M * (2^WW - 1) fits in WW+AW+1 bits.
    function automatic int unsigned acc_width(input int unsigned ww, input int unsigned aw);
        return ww + aw + 1;
    endfunction

    // Upper saturation bound of an n-bit output code, 2^n - 1.
    function automatic longint unsigned sat_bound(input int unsigned n);
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/adc_sar_redundant_reconstruction_if.sv
// Comparator / back-end / calibration-port bundle of the SAR reconstruction block.
interface adc_sar_redundant_reconstruction_if #(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int WW = N + 1,
    parameter int AW = $clog2(M)
);
    logic          start;
    logic          cmp_valid;
    logic          cmp;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          busy;
    logic [N-1:0]  dout;
    logic          dout_valid;
    logic          sat;

    modport master (
        output start, cmp_valid, cmp, wr_en, wr_addr, wr_data,
        input  busy, dout, dout_valid, sat
    );

    modport slave (
        input  start, cmp_valid, cmp, wr_en, wr_addr, wr_data,
        output busy, dout, dout_valid, sat
    );
endinterface

// File: rtl/adc_sar_weight_regs.sv
// M x WW step-weight register file: one write port, one combinational read port, binary reset weights.
module adc_sar_weight_regs
    import adc_sar_redundant_reconstruction_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int WW = N + 1,
    parameter int AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [WW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [WW-1:0] rd_data_o
);
    localparam logic [AW:0] DEPTH = (AW + 1)'(M);

    logic [WW-1:0] w_q [M];
    logic          addr_ok;

    assign addr_ok = ({1'b0, wr_addr_i} < DEPTH);

    for (genvar g = 0; g < M; g++) begin : g_w
        // 2^(N-1) >> g gives 2^(N-1-g) for the binary steps and 0 for the redundant tail.
        localparam logic [WW-1:0] RST_VAL = (WW'(1) << (N - 1)) >> g;

        always_ff @(posedge clk) begin
            if (!rstb) begin
                w_q[g] <= RST_VAL;
            end else if (wr_en_i && addr_ok && (wr_addr_i == AW'(g))) begin
                w_q[g] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = w_q[rd_addr_i];
endmodule

// File: rtl/adder_cla.sv
// Generic N-bit carry-lookahead adder; each carry is a flat generate/propagate product.
module adder_cla #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o
);
    logic [N-2:0] g;
    logic [N-1:0] p;
    logic [N-1:0] cvec;
    logic         gl;
    logic         pl;

    assign g = a_i[N-2:0] & b_i[N-2:0];
    assign p = a_i ^ b_i;

    always_comb begin
        cvec    = '0;
        cvec[0] = cin_i;
        gl      = 1'b0;
        pl      = 1'b0;
        for (int unsigned k = 1; k < N; k++) begin
            gl = 1'b0;
            pl = 1'b1;
            for (int unsigned j = k; j > 0; j--) begin
                gl = gl | (pl & g[j-1]);
                pl = pl & p[j-1];
            end
            cvec[k] = gl | (pl & cin_i);
        end
    end

    assign sum_o = p ^ cvec;
endmodule

// File: rtl/adc_sar_redundant_reconstruction.sv
// SAR code reconstruction with programmable redundant step weights, saturation and valid pulse.
// Optional signed output offset enabled by defining ADC_SAR_RECON_OFFSET_EN.
module adc_sar_redundant_reconstruction
    import adc_sar_redundant_reconstruction_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int WW = N + 1,
    parameter int AW = $clog2(M)
) (
    input logic clk,
    input logic rstb,
`ifdef ADC_SAR_RECON_OFFSET_EN
    input logic signed [N:0] offset,
`endif
    adc_sar_redundant_reconstruction_if.slave bus
);
    localparam int              ACCW      = int'(acc_width(WW, AW));
    localparam logic [ACCW-1:0] SAT_MAX   = ACCW'(sat_bound(N));
    localparam logic [AW-1:0]   LAST_STEP = AW'(M - 1);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   step_q, step_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            sat_q, sat_d;

    logic [WW-1:0]   weight;
    logic [ACCW-1:0] addend;
    logic [ACCW-1:0] acc_sum;
    logic [N-1:0]    res_dout;
    logic            res_sat;

    // Weight table is frozen while a conversion is in flight.
    adc_sar_weight_regs #(
        .N (N),
        .M (M),
        .WW(WW),
        .AW(AW)
    ) u_wregs (
        .clk      (clk),
        .rstb     (rstb),
        .wr_en_i  (bus.wr_en & ~busy_q),
        .wr_addr_i(bus.wr_addr),
        .wr_data_i(bus.wr_data),
        .rd_addr_i(step_q),
        .rd_data_o(weight)
    );

    assign addend = bus.cmp ? ACCW'(weight) : '0;

    adder_cla #(
        .N(ACCW)
    ) u_acc_add (
        .a_i  (acc_q),
        .b_i  (addend),
        .cin_i(1'b0),
        .sum_o(acc_sum)
    );

`ifdef ADC_SAR_RECON_OFFSET_EN
    logic signed [ACCW:0] res_s;

    always_comb begin
        res_s    = $signed({1'b0, acc_q}) + $signed({{(ACCW - N){offset[N]}}, offset});
        res_dout = res_s[N-1:0];
        res_sat  = 1'b0;
        if (res_s[ACCW]) begin
            res_dout = '0;
            res_sat  = 1'b1;
        end else if (res_s > $signed({1'b0, SAT_MAX})) begin
            res_dout = '1;
            res_sat  = 1'b1;
        end
    end
`else
    always_comb begin
        res_dout = acc_q[N-1:0];
        res_sat  = 1'b0;
        if (acc_q > SAT_MAX) begin
            res_dout = '1;
            res_sat  = 1'b1;
        end
    end
`endif

    // The final strobe sets last_q; CONV holds one more cycle so DONE outputs land two edges later.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        acc_d        = acc_q;
        last_d       = last_q;
        busy_d       = busy_q;
        dout_d       = dout_q;
        sat_d        = sat_q;
        dout_valid_d = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bus.start) begin
                    state_d = R_CONV;
                    acc_d   = '0;
                    step_d  = '0;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            R_CONV: begin
                if (bus.start) begin
                    acc_d  = '0;
                    step_d = '0;
                    last_d = 1'b0;
                end else if (last_q) begin
                    state_d = R_DONE;
                    last_d  = 1'b0;
                end else if (bus.cmp_valid) begin
                    acc_d = acc_sum;
                    if (step_q == LAST_STEP) begin
                        step_d = '0;
                        last_d = 1'b1;
                    end else begin
                        step_d = step_q + AW'(1);
                    end
                end
            end
            R_DONE: begin
                state_d      = R_IDLE;
                busy_d       = 1'b0;
                dout_d       = res_dout;
                sat_d        = res_sat;
                dout_valid_d = 1'b1;
            end
            default: begin
                state_d = R_IDLE;
                busy_d  = 1'b0;
                step_d  = '0;
                acc_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= R_IDLE;
            step_q       <= '0;
            acc_q        <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sat_q        <= sat_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sat        = sat_q;
endmodule

// File: tb/tb_adc_sar_redundant_reconstruction.sv
// Bench for adc_sar_redundant_reconstruction: M=8 and M=10 instances, scoreboard on dout_valid.
// Offset cases are included when ADC_SAR_RECON_OFFSET_EN is defined.
module tb_adc_sar_redundant_reconstruction;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    adc_sar_redundant_reconstruction_if #(.N(8), .M(8))  if8 ();
    adc_sar_redundant_reconstruction_if #(.N(8), .M(10)) if10 ();

`ifdef ADC_SAR_RECON_OFFSET_EN
    logic signed [8:0] offs = '0;
`endif

    adc_sar_redundant_reconstruction #(.N(8), .M(8)) u_dut8 (
        .clk (clk),
        .rstb(rstb),
`ifdef ADC_SAR_RECON_OFFSET_EN
        .offset(offs),
`endif
        .bus (if8)
    );

    adc_sar_redundant_reconstruction #(.N(8), .M(10)) u_dut10 (
        .clk (clk),
        .rstb(rstb),
`ifdef ADC_SAR_RECON_OFFSET_EN
        .offset(offs),
`endif
        .bus (if10)
    );

    typedef struct {
        logic [7:0] dout;
        logic       sat;
    } exp_t;

    typedef struct {
        int         which;
        logic [9:0] bits;
        int         steps;
        logic [7:0] dout;
        logic       sat;
    } vec_t;

    exp_t q8[$];
    exp_t q10[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void scb(input int which, input logic [7:0] d, input logic s);
        exp_t e;
        if ((which == 8 && q8.size() == 0) || (which == 10 && q10.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid_m%0d: got dout %0d with no pending sample", which, d);
        end else begin
            e = (which == 8) ? q8.pop_front() : q10.pop_front();
            chk($sformatf("dout_m%0d", which), 32'(d), 32'(e.dout));
            chk($sformatf("sat_m%0d", which), 32'(s), 32'(e.sat));
        end
    endfunction

    always @(negedge clk) begin
        if (if8.dout_valid === 1'b1) scb(8, if8.dout, if8.sat);
        if (if10.dout_valid === 1'b1) scb(10, if10.dout, if10.sat);
    end

    task automatic drive(input int which, input logic st, input logic cv, input logic c);
        @(negedge clk);
        if (which == 8) begin
            if8.start = st; if8.cmp_valid = cv; if8.cmp = c;
        end else begin
            if10.start = st; if10.cmp_valid = cv; if10.cmp = c;
        end
    endtask

    task automatic idle(input int which, input int n);
        repeat (n) drive(which, 1'b0, 1'b0, 1'b0);
    endtask

    // Step 0 (MSB step) takes bits[steps-1].
    task automatic strobes(input int which, input logic [9:0] bits, input int steps);
        for (int i = 0; i < steps; i++) drive(which, 1'b0, 1'b1, bits[steps-1-i]);
    endtask

    task automatic expect_res(input int which, input logic [7:0] d, input logic s);
        exp_t e;
        e.dout = d;
        e.sat  = s;
        if (which == 8) q8.push_back(e);
        else q10.push_back(e);
    endtask

    task automatic convert(input int which, input logic [9:0] bits, input int steps,
                           input logic [7:0] d, input logic s);
        expect_res(which, d, s);
        drive(which, 1'b1, 1'b0, 1'b0);
        strobes(which, bits, steps);
        idle(which, 3);
    endtask

    task automatic wr(input int which, input logic [3:0] addr, input logic [8:0] data);
        @(negedge clk);
        if (which == 8) begin
            if8.wr_en = 1'b1; if8.wr_addr = addr[2:0]; if8.wr_data = data;
        end else begin
            if10.wr_en = 1'b1; if10.wr_addr = addr; if10.wr_data = data;
        end
        @(negedge clk);
        if8.wr_en  = 1'b0;
        if10.wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[12];
        int   wv[10];

        vt[0]  = '{8,  10'h080,        8,  8'd128, 1'b0};
        vt[1]  = '{8,  10'h0FF,        8,  8'd255, 1'b0};
        vt[2]  = '{8,  10'h000,        8,  8'd0,   1'b0};
        vt[3]  = '{8,  10'h0A5,        8,  8'd165, 1'b0};
        vt[4]  = '{8,  10'h03C,        8,  8'd60,  1'b0};
        vt[5]  = '{10, 10'b1011001001, 10, 8'd197, 1'b0};
        vt[6]  = '{10, 10'b1111111111, 10, 8'd255, 1'b1};
        vt[7]  = '{10, 10'b1110111011, 10, 8'd255, 1'b0};
        vt[8]  = '{10, 10'b1111000000, 10, 8'd255, 1'b1};
        vt[9]  = '{10, 10'b0111111111, 10, 8'd163, 1'b0};
        vt[10] = '{10, 10'b1101000000, 10, 8'd224, 1'b0};
        vt[11] = '{10, 10'b0000000000, 10, 8'd0,   1'b0};
        wv = '{128, 64, 32, 32, 16, 8, 4, 4, 2, 1};

        if8.start = 1'b0;  if8.cmp_valid = 1'b0;  if8.cmp = 1'b0;
        if8.wr_en = 1'b0;  if8.wr_addr = '0;      if8.wr_data = '0;
        if10.start = 1'b0; if10.cmp_valid = 1'b0; if10.cmp = 1'b0;
        if10.wr_en = 1'b0; if10.wr_addr = '0;     if10.wr_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy8", 32'(if8.busy), 0);
        chk("rst_dout8", 32'(if8.dout), 0);
        chk("rst_valid8", 32'(if8.dout_valid), 0);
        chk("rst_sat8", 32'(if8.sat), 0);
        chk("rst_busy10", 32'(if10.busy), 0);
        chk("rst_dout10", 32'(if10.dout), 0);
        chk("rst_valid10", 32'(if10.dout_valid), 0);
        chk("rst_sat10", 32'(if10.sat), 0);
        rstb = 1'b1;
        idle(8, 2);

        // M=10 with reset weights: tail steps weigh 0, exactly 255 is not clipped.
        convert(10, 10'b1111111111, 10, 8'd255, 1'b0);
        for (int i = 0; i < 10; i++) wr(10, 4'(i), 9'(wv[i]));

        for (int i = 0; i < 12; i++)
            convert(vt[i].which, vt[i].bits, vt[i].steps, vt[i].dout, vt[i].sat);

        // Latency: valid exactly two edges after the final strobe, one cycle wide.
        expect_res(8, 8'd129, 1'b0);
        drive(8, 1'b1, 1'b0, 1'b0);
        strobes(8, 10'h081, 8);
        idle(8, 1);
        chk("lat_e1_valid", 32'(if8.dout_valid), 0);
        chk("lat_e1_busy", 32'(if8.busy), 1);
        idle(8, 1);
        chk("lat_e2_valid", 32'(if8.dout_valid), 0);
        idle(8, 1);
        chk("lat_e3_valid", 32'(if8.dout_valid), 1);
        chk("lat_e3_busy", 32'(if8.busy), 0);
        chk("lat_e3_dout", 32'(if8.dout), 129);
        idle(8, 1);
        chk("lat_e4_valid", 32'(if8.dout_valid), 0);
        chk("lat_hold_dout", 32'(if8.dout), 129);

        // Abort after 4 strobes, then a clean 0xA5 conversion.
        expect_res(8, 8'd165, 1'b0);
        drive(8, 1'b1, 1'b0, 1'b0);
        strobes(8, 10'h00F, 4);
        drive(8, 1'b1, 1'b0, 1'b0);
        strobes(8, 10'h0A5, 8);
        idle(8, 5);
        chk("abort_pending", 32'(q8.size()), 0);

        // Start coincident with the final strobe discards that sample.
        expect_res(8, 8'd60, 1'b0);
        drive(8, 1'b1, 1'b0, 1'b0);
        strobes(8, 10'h07F, 7);
        drive(8, 1'b1, 1'b1, 1'b1);
        strobes(8, 10'h03C, 8);
        idle(8, 5);
        chk("final_restart_pending", 32'(q8.size()), 0);

        // Start during DONE is ignored; strobes in IDLE do not start anything.
        expect_res(8, 8'd90, 1'b0);
        drive(8, 1'b1, 1'b0, 1'b0);
        strobes(8, 10'h05A, 8);
        idle(8, 1);
        drive(8, 1'b1, 1'b0, 1'b0);
        idle(8, 1);
        chk("done_start_busy", 32'(if8.busy), 0);
        strobes(8, 10'h0FF, 3);
        idle(8, 1);
        chk("idle_strobe_busy", 32'(if8.busy), 0);
        idle(8, 2);

`ifdef ADC_SAR_RECON_OFFSET_EN
        offs = -9'sd10;
        convert(8, 10'h005, 8, 8'd0, 1'b1);
        convert(8, 10'h00A, 8, 8'd0, 1'b0);
        offs = 9'sd3;
        convert(8, 10'h064, 8, 8'd103, 1'b0);
        convert(8, 10'h0FE, 8, 8'd255, 1'b1);
        offs = '0;
`endif

        // Write while busy is dropped; a write in IDLE lands for the next conversion.
        expect_res(8, 8'd128, 1'b0);
        drive(8, 1'b1, 1'b0, 1'b0);
        drive(8, 1'b0, 1'b1, 1'b1);
        if8.wr_en = 1'b1; if8.wr_addr = 3'd0; if8.wr_data = 9'd1;
        drive(8, 1'b0, 1'b1, 1'b0);
        if8.wr_en = 1'b0;
        strobes(8, 10'h000, 6);
        idle(8, 3);
        convert(8, 10'h080, 8, 8'd128, 1'b0);
        wr(8, 4'd0, 9'd1);
        convert(8, 10'h080, 8, 8'd1, 1'b0);
        convert(8, 10'h0FF, 8, 8'd128, 1'b0);

        // One-cycle reset mid-conversion.
        drive(8, 1'b1, 1'b0, 1'b0);
        strobes(8, 10'h00F, 4);
        drive(8, 1'b0, 1'b0, 1'b0);
        rstb = 1'b0;
        drive(8, 1'b0, 1'b0, 1'b0);
        rstb = 1'b1;
        chk("midrst_busy", 32'(if8.busy), 0);
        chk("midrst_dout", 32'(if8.dout), 0);
        chk("midrst_sat", 32'(if8.sat), 0);
        chk("midrst_dout10", 32'(if10.dout), 0);
        idle(8, 4);
        convert(8, 10'h080, 8, 8'd128, 1'b0);
        convert(10, 10'b1111111111, 10, 8'd255, 1'b0);
        idle(8, 2);

        chk("pending_m8", 32'(q8.size()), 0);
        chk("pending_m10", 32'(q10.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
